rand_arb: RTL
=============

RAND_ARB -- requirements
Module: rand_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter GAP, default 3: idle cycles enforced between handshakes (0..15).
REQ-003 clk_vga  input  1  sole clock, all state on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rand_i  input  `RAND_WIDTH  free-running random word from the LFSR generator, advances every clk_vga.
REQ-006 en_i  input  1  arbitration enable (low while game paused).
REQ-007 req_i  input  N_REQ  per-requester request, four-phase.
REQ-008 ack_o  output  N_REQ  per-requester acknowledge, at most one bit high.
REQ-009 data_o  output  `RAND_WIDTH  random word latched for the current grant.
REQ-010 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-011 FSM states IDLE, HOLD, COOL, registered; encoding free.
REQ-012 IDLE: if en_i=1 and req_i!=0, the SHALL grant index g be the first set bit of req_i scanning upward from ptr, wrapping N_REQ-1 -> 0.
REQ-013 On that edge: data_o <= rand_i, ack_o <= onehot(g), ptr <= (g+1) mod N_REQ, state -> HOLD.
REQ-014 Latency: ack_o[g] high the cycle after the edge sampling req_i[g]=1 in IDLE (1 cycle).
REQ-015 IDLE with en_i=0 or req_i=0: no grant, ack_o=0, data_o and ptr hold.
REQ-016 HOLD: ack_o[g] and data_o held stable while req_i[g]=1; en_i and other req bits ignored.
REQ-017 HOLD with req_i[g]=0 sampled: ack_o <= 0; state -> COOL with counter <= GAP-1, or -> IDLE directly when GAP=0.
REQ-018 COOL: counter decrements each cycle; at counter=0 state -> IDLE; no grants during COOL.
REQ-019 Grants separated by at least GAP+2 cycles, so consecutive requesters receive rand_i sampled on different edges.
REQ-020 Requester dropping req_i[g] in the cycle ack rises: handshake completes normally (ack high exactly one cycle).
REQ-021 Requester raising req in HOLD/COOL: stays pending, served in later IDLE per round-robin; no requests lost.
REQ-022 ptr width ceil(log2 N_REQ); wraps modulo N_REQ; counter width 4 bits.
REQ-023 data_o never changes except on a grant edge or reset.
REQ-024 busy_o combinational from state only.

Reset
REQ-025 rst high, any time (including mid-HOLD): state=IDLE, ack_o=0, data_o=0, ptr=0, counter=0, busy_o=0 immediately, no clock needed.
REQ-026 After rst falls, first grant evaluated on the first clk_vga edge with rst low.
REQ-027 Requester whose handshake was cut by reset re-arbitrates as a fresh request.

Verification
REQ-028 Single request: rand_i=8'h5A, req_i=4'b0100 at edge 0 -> edge 1 ack_o=4'b0100, data_o=8'h5A, busy_o=1; drop req -> ack_o=0 next edge; IDLE after 3 COOL cycles.
REQ-029 Round-robin: req_i=4'b1111 held, each requester drops req after its ack -> grant order 0,1,2,3,0; GAP=3 gives 5-cycle spacing between ack rises.
REQ-030 Pause: en_i=0 with req_i=4'b0010 for 10 cycles -> ack_o stays 0; en_i=1 -> ack_o=4'b0010 next edge.
REQ-031 Reset mid-HOLD: ack_o=4'b0001, assert rst between edges -> ack_o=0, data_o=0 asynchronously; after release with req_i[0]=1 -> re-granted, data_o = new rand_i.
REQ-032 GAP=0, N_REQ=2, req_i=2'b11 with single-cycle-ack requesters -> grants alternate 0,1,0,1 every 2 cycles, data_o differs each grant as rand_i steps.
REQ-033 Assertions every cycle: ack_o one-hot or zero; data_o stable while any ack_o bit is high.

Source files
------------

// File: rtl/rand_arb.sv
// rand_arb: round-robin arbiter that hands each requester a latched random word over a
// four-phase req/ack handshake, with a fixed idle gap enforced between handshakes.
`ifndef RAND_WIDTH
`define RAND_WIDTH 8
`endif

module rand_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GAP   = 3
) (
  input  logic                   clk_vga,
  input  logic                   rst,
  input  logic [`RAND_WIDTH-1:0] rand_i,
  input  logic                   en_i,
  input  logic [N_REQ-1:0]       req_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [`RAND_WIDTH-1:0] data_o,
  output logic                   busy_o
);

  localparam int unsigned PtrW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]  CntInit = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StHold, StCool} state_e;

  state_e                   state_q, state_d;
  logic [PtrW-1:0]          ptr_q, ptr_d;
  logic [PtrW-1:0]          gnt_q, gnt_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [N_REQ-1:0]         ack_q, ack_d;
  logic [`RAND_WIDTH-1:0]   data_q, data_d;

  // Round-robin pick: first set request at or above ptr, wrapping to 0.
  logic                     pick_vld;
  logic [PtrW-1:0]          pick_idx;
  logic [PtrW-1:0]          cand_idx;
  logic [PtrW-1:0]          pick_nxt;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_idx = PtrW'((32'(ptr_q) + 32'(i)) % N_REQ);
      if (!pick_vld && req_i[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
    pick_nxt = PtrW'((32'(pick_idx) + 32'd1) % N_REQ);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        ack_d = '0;
        if (en_i && pick_vld) begin
          gnt_d           = pick_idx;
          ptr_d           = pick_nxt;
          ack_d[pick_idx] = 1'b1;
          data_d          = rand_i;
          state_d         = StHold;
        end
      end
      StHold: begin
        // Only the granted requester's line matters until it releases.
        if (!req_i[gnt_q]) begin
          ack_d = '0;
          if (GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StCool;
            cnt_d   = CntInit;
          end
        end
      end
      StCool: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        ack_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;
  assign busy_o = (state_q != StIdle);

endmodule
